// File: rtl/edge_event_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : edge_pkg
// Brief    : Shared constants for the edge-event arbiter slice.
// Revision : 1.0
// ============================================================================
package edge_pkg;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin grant, searching from last+1 with wrap.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 gnt_any
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] idx;

    // Walk from the farthest candidate to the nearest so the nearest hit is the final assignment.
    always_comb begin
        gnt_id  = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % N);
            if (req[idx]) begin
                gnt_id  = idx;
                gnt_any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : edge_event_arbiter
// Brief    : Per-channel edge capture into pending events, serialised by RR.
// Revision : 1.0
// ============================================================================
module edge_event_arbiter
    import edge_pkg::*;
#(
    parameter int N         = 4,
    parameter int EDGE_MODE = EDGE_RISE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         x,
    input  logic [N-1:0]         en,
    input  logic                 evt_ready,
    input  logic                 clr_ovf,
    output logic                 evt_valid,
    output logic [$clog2(N)-1:0] evt_id,
    output logic [N-1:0]         evt_ovf
);

    localparam int IW = $clog2(N);

    logic [N-1:0]  x_q, x_d;
    logic          armed_q, armed_d;
    logic [N-1:0]  pending_q, pending_d;
    logic [N-1:0]  ovf_q, ovf_d;
    logic [0:0]    state_q, state_d;
    logic          evt_valid_q, evt_valid_d;
    logic [IW-1:0] evt_id_q, evt_id_d;
    logic [IW-1:0] last_q, last_d;

    logic [N-1:0]  edge_det;
    logic [N-1:0]  edge_qual;
    logic [N-1:0]  presenting;
    logic [N-1:0]  hs_clr;
    logic [IW-1:0] gnt_id;
    logic          gnt_any;

    if (EDGE_MODE == EDGE_RISE) begin : g_rise
        assign edge_det = x & ~x_q;
    end else if (EDGE_MODE == EDGE_FALL) begin : g_fall
        assign edge_det = ~x & x_q;
    end else begin : g_both
        assign edge_det = x ^ x_q;
    end

    rr_arbiter #(.N(N)) u_rr (
        .req     (pending_q),
        .last    (last_q),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    // Pending and overflow bookkeeping; a fresh edge always beats a clearing handshake.
    always_comb begin
        x_d       = x;
        armed_d   = 1'b1;
        edge_qual = edge_det & en & {N{armed_q}};
        pending_d = pending_q;
        for (int i = 0; i < N; i++) begin
            presenting[i] = evt_valid_q && (evt_id_q == IW'(i));
            hs_clr[i]     = presenting[i] && evt_ready;
            if (edge_qual[i]) begin
                pending_d[i] = 1'b1;
            end else if (hs_clr[i] || (!en[i] && !presenting[i])) begin
                pending_d[i] = 1'b0;
            end
        end
        ovf_d = (ovf_q & ~{N{clr_ovf}}) | (edge_qual & pending_q & ~hs_clr);
    end

    always_comb begin
        state_d     = state_q;
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        last_d      = last_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    evt_id_d    = gnt_id;
                    evt_valid_d = 1'b1;
                    state_d     = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (evt_ready) begin
                    last_d      = evt_id_q;
                    evt_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                evt_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q         <= '0;
            armed_q     <= 1'b0;
            pending_q   <= '0;
            ovf_q       <= '0;
            state_q     <= ST_IDLE;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            last_q      <= IW'(N - 1);
        end else begin
            x_q         <= x_d;
            armed_q     <= armed_d;
            pending_q   <= pending_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            last_q      <= last_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign evt_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_event_arbiter
// Brief    : Directed scenarios plus random traffic against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_edge_event_arbiter;

    localparam int N    = 4;
    localparam int MODE = 0;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] x;
    logic [N-1:0] en;
    logic         evt_ready;
    logic         clr_ovf;
    logic         evt_valid;
    logic [1:0]   evt_id;
    logic [N-1:0] evt_ovf;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    bit [N-1:0] m_xq, m_pend, m_ovf;
    bit         m_armed, m_valid;
    int         m_id, m_last;
    int         got[$];

    always #5 clk = ~clk;

    edge_event_arbiter #(.N(N), .EDGE_MODE(MODE)) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .en        (en),
        .evt_ready (evt_ready),
        .clr_ovf   (clr_ovf),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_ovf   (evt_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_edge(bit cur, bit prev);
        case (MODE)
            0:       return cur && !prev;
            1:       return !cur && prev;
            default: return cur != prev;
        endcase
    endfunction

    task automatic model_update();
        bit [N-1:0] n_pend, n_ovf;
        bit e, pres, hsc, found;
        int c;
        if (rst) begin
            m_xq = '0; m_armed = 0; m_pend = '0; m_ovf = '0;
            m_valid = 0; m_id = 0; m_last = N - 1;
            return;
        end
        n_pend = m_pend;
        n_ovf  = m_ovf;
        for (int i = 0; i < N; i++) begin
            e    = is_edge(x[i], m_xq[i]) && en[i] && m_armed;
            pres = m_valid && (m_id == i);
            hsc  = pres && evt_ready;
            if (e) n_pend[i] = 1;
            else if (hsc || (!en[i] && !pres)) n_pend[i] = 0;
            if (clr_ovf) n_ovf[i] = 0;
            if (e && m_pend[i] && !hsc) n_ovf[i] = 1;
        end
        if (!m_valid) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!found && m_pend[c]) begin
                    found = 1;
                    m_id  = c;
                end
            end
            if (found) m_valid = 1;
        end else if (evt_ready) begin
            m_last  = m_id;
            m_valid = 0;
        end
        m_pend  = n_pend;
        m_ovf   = n_ovf;
        m_xq    = x;
        m_armed = 1;
    endtask

    // One clock: log the handshake this edge performs, advance the model, compare after the edge.
    task automatic step();
        if (!rst && evt_valid === 1'b1 && evt_ready) got.push_back(int'(evt_id));
        model_update();
        @(posedge clk);
        #1;
        chk("valid", {31'd0, evt_valid}, {31'd0, m_valid});
        if (m_valid) chk("id", {30'd0, evt_id}, m_id);
        chk("ovf", {28'd0, evt_ovf}, {28'd0, m_ovf});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic chk_got(input string tag, input int exp[$]);
        chk({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk(tag, got[i], exp[i]);
        got.delete();
    endtask

    initial begin
        rst = 1'b1; x = '1; en = '1; evt_ready = 1'b1; clr_ovf = 1'b0;
        steps(2);
        chk("reset_valid", {31'd0, evt_valid}, 0);
        chk("reset_id", {30'd0, evt_id}, 0);
        chk("reset_ovf", {28'd0, evt_ovf}, 0);

        // High levels at reset release never produce events
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t1_valid", {31'd0, evt_valid}, 0);
        end
        chk("t1_ovf", {28'd0, evt_ovf}, 0);

        // Single rising edge on ch2: pending at k, valid after k+1, one cycle long
        x = 4'b1011; step();
        x = 4'b1111; step();
        chk("t2_lat_k", {31'd0, evt_valid}, 0);
        step();
        chk("t2_valid", {31'd0, evt_valid}, 1);
        chk("t2_id", {30'd0, evt_id}, 2);
        step();
        chk("t2_drop", {31'd0, evt_valid}, 0);
        got.delete();

        // Same-cycle edges on 0,1,3 from fresh priority, then wrap from last=3
        pulse_reset(); steps(2);
        x = 4'b0100; step();
        x = 4'b1111; steps(8);
        chk_got("t3_seq", '{0, 1, 3});
        x = 4'b0110; step();
        x = 4'b1111; steps(6);
        chk_got("t3_wrap", '{0, 3});

        // Stalled consumer with a second ch1 edge: overflow, single delivery
        evt_ready = 1'b0;
        x = 4'b1101; step();
        x = 4'b1111; steps(2);
        x = 4'b1101; step();
        x = 4'b1111; steps(3);
        chk("t4_valid", {31'd0, evt_valid}, 1);
        chk("t4_id", {30'd0, evt_id}, 1);
        chk("t4_ovf", {28'd0, evt_ovf}, 4'b0010);
        evt_ready = 1'b1; steps(5);
        chk_got("t4_once", '{1});
        clr_ovf = 1'b1; step();
        clr_ovf = 1'b0;
        chk("t4_clr", {28'd0, evt_ovf}, 0);

        // Disabled channel ignored; enable dropped mid-presentation still delivers
        en = 4'b1101;
        x = 4'b1101; step();
        x = 4'b1111; steps(4);
        chk_got("t5_masked", '{});
        en = 4'b1111; evt_ready = 1'b0;
        x = 4'b1011; step();
        x = 4'b1111; steps(2);
        chk("t5_id", {30'd0, evt_id}, 2);
        en = 4'b1011; steps(2);
        chk("t5_hold", {31'd0, evt_valid}, 1);
        evt_ready = 1'b1; steps(3);
        chk_got("t5_deliver", '{2});
        en = 4'b1111;

        // Reset in the middle of a presentation with ch1 and ch3 pending
        evt_ready = 1'b0;
        x = 4'b0101; step();
        x = 4'b1111; steps(2);
        chk("t6_pre_valid", {31'd0, evt_valid}, 1);
        pulse_reset();
        chk("t6_valid", {31'd0, evt_valid}, 0);
        chk("t6_ovf", {28'd0, evt_ovf}, 0);
        evt_ready = 1'b1; steps(6);
        chk_got("t6_none", '{});

        // Random traffic checked cycle by cycle against the model
        for (int i = 0; i < 800; i++) begin
            x         = N'($urandom);
            en        = ($urandom_range(0, 7) == 0) ? N'($urandom) : '1;
            evt_ready = 1'($urandom_range(0, 1));
            clr_ovf   = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
